// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART receive/transmit pair:
//   - rx_state_e   : receiver FSM states
//   - OVERSAMPLE   : oversampling ratio of the receiver (ticks per bit)
//   - SAMPLE_A/B/C : tick indices inside a bit at which the line is sampled
//   - uart_div()   : clock divisor for a given clock and rate, rounded to nearest
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_e;

    localparam int OVERSAMPLE = 16;

    // Three samples centred on mid-bit; tick 0 is the first tick after the phase reset.
    localparam int SAMPLE_A = 7;
    localparam int SAMPLE_B = 8;
    localparam int SAMPLE_C = 9;

    // Divisor producing OVERSAMPLE ticks per bit, rounded to nearest integer.
    // The sender calls this with its own oversample-free rate.
    function automatic int unsigned uart_div(input int unsigned clk_freq,
                                             input int unsigned baud_rate);
        int unsigned os;
        os = OVERSAMPLE;
        return (clk_freq + (os / 2) * baud_rate) / (os * baud_rate);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick
// Free-running divide-by-DIV counter producing a one-cycle tick every DIV clocks.
// Ports:
//   clk       : system clock
//   rst       : synchronous active-high reset
//   phase_rst : synchronous phase reset; counter restarts from 0, first tick
//               follows DIV clocks after the cycle in which it is asserted
//   tick      : one-cycle pulse every DIV clocks
module uart_baud_tick #(
    parameter int unsigned DIV = 87
) (
    input  logic clk,
    input  logic rst,
    input  logic phase_rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          wrap;

    assign wrap = (cnt_q == LAST);
    // A phase reset suppresses a coincident tick so the new phase starts clean.
    assign tick = wrap && !phase_rst;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (phase_rst || wrap) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
// 8N1 UART receiver with 16x oversampling and 3-sample majority voting.
// Ports:
//   clk   : system clock
//   rst   : synchronous active-high reset
//   rxd   : asynchronous serial input, idle high
//   data  : last good received byte (updates only with avail)
//   avail : one-cycle strobe, data valid
//   busy  : high whenever the receiver is not in IDLE
//   error : one-cycle strobe, stop bit sampled low
//   brk   : one-cycle strobe with error when the frame was all zeros
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned clk_freq  = 160_000_000,
    parameter int unsigned baud_rate = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       avail,
    output logic       busy,
    output logic       error,
    output logic       brk
);

    localparam int unsigned DIV = uart_div(clk_freq, baud_rate);
    localparam int TIDX_W = $clog2(OVERSAMPLE);
    localparam logic [TIDX_W-1:0] IDX_A = TIDX_W'(SAMPLE_A);
    localparam logic [TIDX_W-1:0] IDX_B = TIDX_W'(SAMPLE_B);
    localparam logic [TIDX_W-1:0] IDX_C = TIDX_W'(SAMPLE_C);

    // Two-flop synchroniser; only rx_s is used downstream.
    logic [1:0] sync_q;
    logic [1:0] sync_d;
    logic       rx_s;

    rx_state_e         state_q, state_d;
    logic [TIDX_W-1:0] tick_idx_q, tick_idx_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [1:0]        samp_q, samp_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        data_q, data_d;
    logic              avail_q, avail_d;
    logic              error_q, error_d;
    logic              brk_q, brk_d;

    logic phase_rst;
    logic tick;
    logic maj;
    logic mid_bit;

    assign sync_d = {sync_q[0], rxd};
    assign rx_s   = sync_q[1];

    uart_baud_tick #(
        .DIV(DIV)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .phase_rst(phase_rst),
        .tick     (tick)
    );

    // The third sample is taken live on the decision tick, so the vote uses
    // the two stored samples plus the current line level.
    assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    assign mid_bit = tick && (tick_idx_q == IDX_C);

    always_comb begin
        state_d    = state_q;
        tick_idx_d = tick ? tick_idx_q + 1'b1 : tick_idx_q;
        bit_idx_d  = bit_idx_q;
        samp_d     = samp_q;
        shift_d    = shift_q;
        data_d     = data_q;
        avail_d    = 1'b0;
        error_d    = 1'b0;
        brk_d      = 1'b0;
        phase_rst  = 1'b0;

        if (tick && (tick_idx_q == IDX_A)) begin
            samp_d[0] = rx_s;
        end
        if (tick && (tick_idx_q == IDX_B)) begin
            samp_d[1] = rx_s;
        end

        case (state_q)
            IDLE: begin
                // Hold the divider in phase reset so ticks align to the start edge.
                phase_rst  = 1'b1;
                tick_idx_d = '0;
                if (!rx_s) begin
                    state_d   = START;
                    bit_idx_d = '0;
                end
            end
            START: begin
                if (mid_bit) begin
                    if (maj) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end
            end
            DATA: begin
                // The tick index keeps running across bits, so the next bit's
                // samples land at its own ticks 7/8/9.
                if (mid_bit) begin
                    shift_d[bit_idx_q] = maj;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (mid_bit) begin
                    if (maj) begin
                        // Leave before the stop bit ends to accept back-to-back frames.
                        data_d  = shift_q;
                        avail_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        error_d = 1'b1;
                        brk_d   = (shift_q == 8'h00);
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // A line held low must not be decoded as a train of frames.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= 2'b11;
            state_q    <= IDLE;
            tick_idx_q <= '0;
            bit_idx_q  <= '0;
            samp_q     <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            avail_q    <= 1'b0;
            error_q    <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            tick_idx_q <= tick_idx_d;
            bit_idx_q  <= bit_idx_d;
            samp_q     <= samp_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            avail_q    <= avail_d;
            error_q    <= error_d;
            brk_q      <= brk_d;
        end
    end

    assign data  = data_q;
    assign avail = avail_q;
    assign error = error_q;
    assign brk   = brk_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
`timescale 1ns/1ps
// Bench for uart_rx_sampler. The clock is scaled so one bit is 128 clocks
// (divisor 8), keeping the whole run short.
module tb_uart_rx_sampler;

    localparam int unsigned CLK_FREQ = 14_745_600;
    localparam int unsigned BAUD     = 115_200;
    localparam int BIT = 128;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic [7:0] data;
    logic       avail;
    logic       busy;
    logic       error;
    logic       brk;

    uart_rx_sampler #(
        .clk_freq (CLK_FREQ),
        .baud_rate(BAUD)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .rxd  (rxd),
        .data (data),
        .avail(avail),
        .busy (busy),
        .error(error),
        .brk  (brk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        bit         brk;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;
    logic [7:0] last_good = 8'h00;

    // Monitor bookkeeping
    longint cyc = 0;
    longint last_avail_cyc = 0;
    longint avail_gap = 0;
    bit busy_dropped = 1'b0;
    bit dropped_at_avail = 1'b0;
    bit prev_avail = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push_good(input logic [7:0] b);
        exp_q.push_back(exp_t'{is_err: 1'b0, brk: 1'b0, data: b});
        last_good = b;
    endtask

    // Reference: a low stop bit yields error, with break when the byte is zero,
    // and the output byte keeps the last good value.
    task automatic push_err(input logic [7:0] b);
        exp_q.push_back(exp_t'{is_err: 1'b1, brk: (b == 8'h00), data: last_good});
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int bclk, input bit stop);
        rxd = 1'b0;
        repeat (bclk) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (bclk) @(negedge clk);
        end
        rxd = stop;
        repeat (bclk) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_zero(input string name);
        check({name, "_data"}, {24'h0, data}, 32'h0);
        check({name, "_strobes"}, {28'h0, avail, busy, error, brk}, 32'h0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            prev_avail = 1'b0;
        end else begin
            if (avail && error) begin
                bad++;
                $display("FAIL avail_error_overlap: got avail=1 error=1 expected never both");
            end
            if (brk && !error) begin
                bad++;
                $display("FAIL brk_without_error: got brk=1 error=0 expected brk only with error");
            end
            if (avail && prev_avail) begin
                bad++;
                $display("FAIL avail_width: got avail high 2 cycles expected 1");
            end
            if (avail) begin
                avail_gap        = cyc - last_avail_cyc;
                last_avail_cyc   = cyc;
                dropped_at_avail = busy_dropped;
                busy_dropped     = 1'b0;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_avail: got data=%02h expected no strobe", data);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_err || data !== e.data) begin
                        bad++;
                        $display("FAIL avail_data: got avail data=%02h expected is_err=%0d data=%02h",
                                 data, e.is_err, e.data);
                    end else begin
                        $display("avail data=%02h ok", data);
                    end
                end
            end
            if (error) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_error: got error brk=%0b expected no strobe", brk);
                end else begin
                    e = exp_q.pop_front();
                    if (!e.is_err || brk !== e.brk || data !== e.data) begin
                        bad++;
                        $display("FAIL error_strobe: got error brk=%0b data=%02h expected is_err=%0d brk=%0b data=%02h",
                                 brk, data, e.is_err, e.brk, e.data);
                    end else begin
                        $display("error brk=%0b data=%02h ok", brk, data);
                    end
                end
            end
            if (!busy) busy_dropped = 1'b1;
            prev_avail = avail;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int bc;
        bit st;

        rst = 1'b1;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        idle(20);

        // Two nominal frames
        push_good(8'h55); send_frame(8'h55, BIT, 1'b1); idle(40);
        push_good(8'hA3); send_frame(8'hA3, BIT, 1'b1); idle(40);
        drain("drain_nominal");

        // Back to back, single stop bit
        push_good(8'h00); send_frame(8'h00, BIT, 1'b1);
        push_good(8'hFF); send_frame(8'hFF, BIT, 1'b1);
        idle(40);
        drain("drain_b2b");
        check("b2b_gap_ok", {31'h0, (avail_gap >= 1264 && avail_gap <= 1296)}, 32'h1);
        check("b2b_busy_dropped", {31'h0, dropped_at_avail}, 32'h1);

        // Short low glitch in IDLE
        rxd = 1'b0;
        repeat (20) @(negedge clk);
        rxd = 1'b1;
        check("glitch_busy_seen", {31'h0, busy}, 32'h1);
        repeat (BIT) @(negedge clk);
        check("glitch_busy_clear", {31'h0, busy}, 32'h0);

        // Stop bit low, then a good frame
        push_err(8'h3C); send_frame(8'h3C, BIT, 1'b0); idle(40);
        push_good(8'h12); send_frame(8'h12, BIT, 1'b1); idle(40);
        drain("drain_framing");

        // Line held low for three frame times
        push_err(8'h00);
        rxd = 1'b0;
        repeat (30 * BIT) @(negedge clk);
        check("held_low_busy", {31'h0, busy}, 32'h1);
        rxd = 1'b1;
        repeat (10) @(negedge clk);
        check("held_low_release_idle", {31'h0, busy}, 32'h0);
        idle(40);
        drain("drain_held_low");

        // Reset in the middle of data bit 4 of 0xF0 (remaining bits are all 1)
        b = 8'hF0;
        rxd = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = b[i];
            repeat (BIT) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (BIT / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("midframe_reset");
        rst = 1'b0;
        last_good = 8'h00;
        idle(BIT * 5);
        push_good(8'h7E); send_frame(8'h7E, BIT, 1'b1); idle(40);
        drain("drain_after_reset");

        // Baud mismatch +3% and -3%
        push_good(8'h96); send_frame(8'h96, 124, 1'b1); idle(40);
        push_good(8'h96); send_frame(8'h96, 132, 1'b1); idle(40);
        drain("drain_baud_tol");

        // Randomized frames: random byte, rate within tolerance, occasional bad stop
        for (int k = 0; k < 8; k++) begin
            b  = 8'($urandom_range(0, 255));
            bc = $urandom_range(124, 132);
            st = ($urandom_range(0, 3) != 0);
            if (st) push_good(b);
            else    push_err(b);
            send_frame(b, bc, st);
            idle($urandom_range(10, 100));
        end
        idle(40);
        drain("drain_random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
